// File: rtl/sprite_snapshot_fetch_pkg.sv
// Shared definitions for the sprite register file: address map, fetch order and
// the snapshot fetcher's state encoding.
package sprite_snapshot_fetch_pkg;

    localparam int NUM_SPRITES = 5;
    localparam int NUM_REGS    = 17;

    localparam logic [5:0] PAC_X      = 6'd0;
    localparam logic [5:0] PAC_Y      = 6'd1;
    localparam logic [5:0] PAC_ROT    = 6'd2;
    localparam logic [5:0] MAP_X      = 6'd6;
    localparam logic [5:0] MAP_Y      = 6'd7;
    localparam logic [5:0] BLINKY_X   = 6'd8;
    localparam logic [5:0] BLINKY_Y   = 6'd9;
    localparam logic [5:0] BLINKY_ROT = 6'd10;
    localparam logic [5:0] PINKY_X    = 6'd14;
    localparam logic [5:0] PINKY_Y    = 6'd15;
    localparam logic [5:0] PINKY_ROT  = 6'd16;
    localparam logic [5:0] INKY_X     = 6'd20;
    localparam logic [5:0] INKY_Y     = 6'd21;
    localparam logic [5:0] INKY_ROT   = 6'd22;
    localparam logic [5:0] CLYDE_X    = 6'd26;
    localparam logic [5:0] CLYDE_Y    = 6'd27;
    localparam logic [5:0] CLYDE_ROT  = 6'd28;
    localparam logic [5:0] FRAME_LOCK = 6'd32;

    // Staging slots: PacMan triple, map x/y, then one triple per ghost.
    localparam logic [4:0] LAST_IDX  = 5'd16;
    localparam logic [4:0] MAP_X_IDX = 5'd3;
    localparam logic [4:0] MAP_Y_IDX = 5'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_LOCK   = 2'd2,
        ST_COMMIT = 2'd3
    } fetch_state_e;

    function automatic logic [5:0] addr_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return PAC_X;
            5'd1:    return PAC_Y;
            5'd2:    return PAC_ROT;
            5'd3:    return MAP_X;
            5'd4:    return MAP_Y;
            5'd5:    return BLINKY_X;
            5'd6:    return BLINKY_Y;
            5'd7:    return BLINKY_ROT;
            5'd8:    return PINKY_X;
            5'd9:    return PINKY_Y;
            5'd10:   return PINKY_ROT;
            5'd11:   return INKY_X;
            5'd12:   return INKY_Y;
            5'd13:   return INKY_ROT;
            5'd14:   return CLYDE_X;
            5'd15:   return CLYDE_Y;
            5'd16:   return CLYDE_ROT;
            default: return 6'd0;
        endcase
    endfunction

    // Staging index of the x register for a sprite slot; y and rot follow it.
    function automatic logic [4:0] slot_base(input logic [2:0] slot);
        case (slot)
            3'd0:    return 5'd0;
            3'd1:    return 5'd5;
            3'd2:    return 5'd8;
            3'd3:    return 5'd11;
            3'd4:    return 5'd14;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_snapshot_fetch.sv
// Per-frame bus initiator: reads the sprite/map registers into staging, releases
// the CPU frame lock, then commits every value to the shadow outputs at once.
module sprite_snapshot_fetch
    import sprite_snapshot_fetch_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 6,
    parameter int                LOCK_ADDR    = 32,
    parameter logic [DATA_W-1:0] LOCK_CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    output logic                          bus_req,
    input  logic                          bus_gnt,
    output logic [ADDR_W-1:0]             reg_addr,
    output logic [DATA_W-1:0]             reg_wdata,
    output logic                          reg_we,
    input  logic [DATA_W-1:0]             reg_rdata,
    output logic [NUM_SPRITES*DATA_W-1:0] spr_x,
    output logic [NUM_SPRITES*DATA_W-1:0] spr_y,
    output logic [2*NUM_SPRITES-1:0]      spr_rot,
    output logic [DATA_W-1:0]             map_x,
    output logic [DATA_W-1:0]             map_y,
    output logic                          snap_valid,
    output logic                          busy,
    output logic [7:0]                    overrun_cnt
);

    fetch_state_e                  state_r;
    logic [4:0]                    idx_r;
    logic                          pending_r;
    logic                          lock_r;
    logic                          bus_req_r;
    logic                          busy_r;
    logic [ADDR_W-1:0]             reg_addr_r;
    logic [DATA_W-1:0]             reg_wdata_r;
    logic                          snap_valid_r;
    logic [7:0]                    overrun_r;
    logic [DATA_W-1:0]             staging_r [NUM_REGS];
    logic [NUM_SPRITES*DATA_W-1:0] spr_x_r;
    logic [NUM_SPRITES*DATA_W-1:0] spr_y_r;
    logic [2*NUM_SPRITES-1:0]      spr_rot_r;
    logic [DATA_W-1:0]             map_x_r;
    logic [DATA_W-1:0]             map_y_r;
    logic                          capture_s;

    assign capture_s = (state_r == ST_READ) && bus_gnt;

    // Fetch sequencer with registered bus-side outputs and frame overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= 5'd0;
            pending_r    <= 1'b0;
            lock_r       <= 1'b0;
            bus_req_r    <= 1'b0;
            busy_r       <= 1'b0;
            reg_addr_r   <= {ADDR_W{1'b0}};
            reg_wdata_r  <= {DATA_W{1'b0}};
            snap_valid_r <= 1'b0;
            overrun_r    <= 8'd0;
        end else begin
            snap_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start || pending_r) begin
                        state_r    <= ST_READ;
                        idx_r      <= 5'd0;
                        pending_r  <= 1'b0;
                        bus_req_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        reg_addr_r <= ADDR_W'(addr_rom(5'd0));
                    end
                end
                ST_READ: begin
                    if (bus_gnt) begin
                        if (idx_r == LAST_IDX) begin
                            state_r     <= ST_LOCK;
                            lock_r      <= 1'b1;
                            reg_addr_r  <= ADDR_W'(LOCK_ADDR);
                            reg_wdata_r <= LOCK_CLR_VAL;
                        end else begin
                            idx_r      <= idx_r + 5'd1;
                            reg_addr_r <= ADDR_W'(addr_rom(idx_r + 5'd1));
                        end
                    end
                end
                ST_LOCK: begin
                    if (bus_gnt) begin
                        state_r     <= ST_COMMIT;
                        lock_r      <= 1'b0;
                        bus_req_r   <= 1'b0;
                        idx_r       <= 5'd0;
                        reg_addr_r  <= {ADDR_W{1'b0}};
                        reg_wdata_r <= {DATA_W{1'b0}};
                    end
                end
                ST_COMMIT: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    snap_valid_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= 5'd0;
                    lock_r      <= 1'b0;
                    bus_req_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    reg_addr_r  <= {ADDR_W{1'b0}};
                    reg_wdata_r <= {DATA_W{1'b0}};
                end
            endcase
            // One frame may queue behind the current run; anything beyond that is dropped.
            if (frame_start && (pending_r || (state_r != ST_IDLE))) begin
                if (!pending_r) begin
                    pending_r <= 1'b1;
                end else if (overrun_r != 8'hFF) begin
                    overrun_r <= overrun_r + 8'd1;
                end
            end
        end
    end

    // Staging capture, one register per granted read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                staging_r[i] <= {DATA_W{1'b0}};
            end
        end else if (capture_s) begin
            staging_r[idx_r] <= reg_rdata;
        end
    end

    // Shadow outputs: loaded from staging in a single cycle so the renderer never sees a mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr_x_r   <= {(NUM_SPRITES*DATA_W){1'b0}};
            spr_y_r   <= {(NUM_SPRITES*DATA_W){1'b0}};
            spr_rot_r <= {(2*NUM_SPRITES){1'b0}};
            map_x_r   <= {DATA_W{1'b0}};
            map_y_r   <= {DATA_W{1'b0}};
        end else if (state_r == ST_COMMIT) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                spr_x_r[s*DATA_W +: DATA_W] <= staging_r[slot_base(3'(s))];
                spr_y_r[s*DATA_W +: DATA_W] <= staging_r[slot_base(3'(s)) + 5'd1];
                spr_rot_r[2*s +: 2]         <= staging_r[slot_base(3'(s)) + 5'd2][1:0];
            end
            map_x_r <= staging_r[MAP_X_IDX];
            map_y_r <= staging_r[MAP_Y_IDX];
        end
    end

    assign bus_req     = bus_req_r;
    assign reg_we      = lock_r & bus_gnt;
    assign reg_addr    = reg_addr_r;
    assign reg_wdata   = reg_wdata_r;
    assign spr_x       = spr_x_r;
    assign spr_y       = spr_y_r;
    assign spr_rot     = spr_rot_r;
    assign map_x       = map_x_r;
    assign map_y       = map_y_r;
    assign snap_valid  = snap_valid_r;
    assign busy        = busy_r;
    assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_sprite_snapshot_fetch.sv
// Randomized bench for sprite_snapshot_fetch against a register-file model and
// a cycle-level expectation of the fetch sequence.
module tb_sprite_snapshot_fetch;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        bus_req;
    logic        bus_gnt;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic [15:0] reg_rdata;
    logic [79:0] spr_x;
    logic [79:0] spr_y;
    logic [9:0]  spr_rot;
    logic [15:0] map_x;
    logic [15:0] map_y;
    logic        snap_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;

    logic [15:0]  regs [64];
    logic [201:0] out_vec;
    logic [201:0] prev_vec;
    int           vectors_applied;
    int           miscompares;

    sprite_snapshot_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_rdata   (reg_rdata),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_rot     (spr_rot),
        .map_x       (map_x),
        .map_y       (map_y),
        .snap_valid  (snap_valid),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    assign reg_rdata = regs[reg_addr];
    assign out_vec   = {spr_x, spr_y, spr_rot, map_x, map_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 64; i++) regs[i] = 16'($urandom);
    endtask

    // k-th register of the fetch list: PacMan x,y,rot, map x,y, then ghost triples 6 apart.
    function automatic logic [5:0] exp_rd_addr(input int k);
        if (k < 3) return 6'(k);
        if (k < 5) return 6'(k + 3);
        return 6'(2 + 6 * ((k - 5) / 3 + 1) + (k - 5) % 3);
    endfunction

    function automatic logic [201:0] model_vec();
        logic [79:0] x;
        logic [79:0] y;
        logic [9:0]  r;
        int          a;
        for (int s = 0; s < 5; s++) begin
            a = (s == 0) ? 0 : 2 + 6 * s;
            x[s*16 +: 16] = regs[a];
            y[s*16 +: 16] = regs[a + 1];
            r[2*s +: 2]   = regs[a + 2][1:0];
        end
        return {x, y, r, regs[6], regs[7]};
    endfunction

    // One frame fetch with a given grant pattern, checked cycle by cycle.
    task automatic run_fetch(input bit rand_gnt, input int st_at, input int st_len, input bit poke);
        bit           pat [64];
        int           grants;
        int           c18;
        int           exp_snap;
        logic [5:0]   exp_addr;
        logic [201:0] m_vec;
        for (int c = 0; c < 64; c++) begin
            if (rand_gnt) pat[c] = (c >= 40) || ($urandom_range(0, 3) != 0);
            else          pat[c] = !((c >= st_at) && (c < st_at + st_len));
        end
        grants = 0;
        c18 = 63;
        for (int c = 0; c < 64; c++) begin
            if (pat[c]) grants++;
            if (grants == 18) begin
                c18 = c;
                break;
            end
        end
        exp_snap = c18 + 2;
        m_vec = model_vec();
        frame_start = 1'b1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        grants = 0;
        for (int c = 0; c <= exp_snap + 1; c++) begin
            bus_gnt = pat[c];
            if (poke && c == 3) regs[0] = regs[0] ^ 16'h5A5A;
            #1;
            if (c > c18)          exp_addr = 6'd0;
            else if (grants < 17) exp_addr = exp_rd_addr(grants);
            else                  exp_addr = 6'd32;
            check_value("reg_addr", reg_addr, exp_addr);
            check_value("reg_we", reg_we, c == c18);
            check_value("reg_wdata", reg_wdata, 16'h0000);
            check_value("busy", busy, c < exp_snap);
            check_value("bus_req", bus_req, c <= c18);
            check_value("snap_valid", snap_valid, c == exp_snap);
            check_value("shadow", out_vec, (c >= exp_snap) ? m_vec : prev_vec);
            if (pat[c]) grants++;
            @(posedge clk); #1;
        end
        prev_vec = m_vec;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_shadow"}, out_vec, 202'd0);
        check_value({tag, "_bus"}, {bus_req, reg_we, reg_addr, reg_wdata, snap_valid, busy}, 26'd0);
        check_value({tag, "_overrun"}, overrun_cnt, 8'd0);
    endtask

    initial begin
        logic [201:0] m1;
        logic [201:0] m2;
        int           n_snap;
        int           snap_at0;
        int           snap_at1;
        vectors_applied = 0;
        miscompares     = 0;
        prev_vec        = 202'd0;
        reset       = 1'b1;
        frame_start = 1'b0;
        bus_gnt     = 1'b0;
        for (int k = 0; k < 64; k++) regs[k] = 16'h0100 + 16'(k);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic fetch with a known register image.
        run_fetch(1'b0, 99, 0, 1'b0);
        check_value("pac_x", spr_x[15:0], 16'h0100);
        check_value("map_y", map_y, 16'h0107);
        check_value("clyde_y", spr_y[79:64], 16'h011B);
        check_value("clyde_rot", spr_rot[9:8], 2'b00);

        // Three-cycle grant stall while the sixth register is on the bus.
        rand_regs();
        run_fetch(1'b0, 5, 3, 1'b0);

        // Rotation registers with upper bits set.
        rand_regs();
        regs[2] = 16'hFFFE; regs[10] = 16'hFFFE; regs[16] = 16'hFFFE;
        regs[22] = 16'hFFFE; regs[28] = 16'hFFFE;
        run_fetch(1'b0, 99, 0, 1'b0);
        check_value("rot_mask", spr_rot, 10'h2AA);

        // Register 0 changes after it has been read.
        rand_regs();
        run_fetch(1'b0, 99, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rand_regs();
            run_fetch(1'b1, 99, 0, 1'b0);
        end

        // Overlapping frame_start pulses: one queued, one dropped.
        rand_regs();
        m1 = model_vec();
        m2 = m1;
        bus_gnt = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        n_snap = 0; snap_at0 = -1; snap_at1 = -1;
        for (int c = 0; c < 60; c++) begin
            frame_start = (c == 4) || (c == 6);
            if (c == 19) begin
                rand_regs();
                m2 = model_vec();
            end
            #1;
            if (snap_valid) begin
                if (n_snap == 0) snap_at0 = c;
                else             snap_at1 = c;
                n_snap++;
            end
            if (c == 19) check_value("ovl_snap1", out_vec, m1);
            if (c == 39) check_value("ovl_snap2", out_vec, m2);
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        check_value("ovl_count", n_snap, 2);
        check_value("ovl_first", snap_at0, 19);
        check_value("ovl_second", snap_at1, 39);
        check_value("ovl_overrun", overrun_cnt, 8'd1);

        // Asynchronous reset in the middle of a run, then a clean full run.
        rand_regs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        prev_vec = 202'd0;
        run_fetch(1'b0, 99, 0, 1'b0);

        // frame_start held high saturates the dropped-frame counter.
        frame_start = 1'b1;
        bus_gnt = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check_value("overrun_sat", overrun_cnt, 8'd255);
        check_value("sat_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
